instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch and sequencing stage that sits directly upstream of the processor core. It walks a program counter through a synchronous-read instruction memory and presents each instruction word on the core's DIN bus with Run asserted. For mvi instructions it also presents the immediate word that follows. It then holds that word until the core reports Done, and stops permanently on a halt word.

## Interface
- ADDR_W, 5: program counter and memory address width.
- DATA_W, 16: instruction and data word width.
- MVI_OP, 3'b001: opcode in word bits [8:6] that carries a trailing immediate word.
- Clock  in  1  single clock; all state updates on the rising edge.
- Resetn  in  1  reset, synchronous and active-low.
- Start  in  1  level enable; fetching proceeds only while high.
- Done  in  1  core has retired the current instruction.
- mem_data  in  DATA_W  memory read data, valid one cycle after mem_addr.
- mem_addr  out  ADDR_W  memory read address.
- DIN  out  DATA_W  word driven to the core.
- Run  out  1  core may execute the word on DIN.
- Halted  out  1  halt word reached.
- pc  out  ADDR_W  address of the next word to fetch.

## Operation
- Reset (Resetn=0 at a rising edge), applicable in any state including mid-instruction:
  - state IDLE; pc=0; instruction and immediate registers 0.
  - Outputs: Run=0, DIN=0, Halted=0, mem_addr=0.
- FSM states and transitions:
  - IDLE: Run=0, mem_addr=pc. Start=1 → FETCH.
  - FETCH: mem_addr=pc → LOAD.
  - LOAD: instr <= mem_data; pc <= pc+1.
    - mem_data[15:9] all ones → HALT.
    - else mem_data[8:6]==MVI_OP → IMM_FETCH.
    - else → ISSUE.
  - IMM_FETCH: mem_addr=pc → IMM_LOAD.
  - IMM_LOAD: imm <= mem_data; pc <= pc+1 → ISSUE.
  - ISSUE: Run=1, DIN=instr → EXEC. Done in this state is ignored.
  - EXEC: Run=1; DIN=imm if instr is mvi, else instr.
    - Done=1 and Start=1 → FETCH.
    - Done=1 and Start=0 → IDLE.
    - Done=0 → stay in EXEC.
  - HALT: Halted=1, Run=0, DIN=0; exits only on reset.
- Start dropping while not in EXEC: the current fetch and issue sequence completes. Once the instruction retires in EXEC, the FSM moves to IDLE.
- pc wraps from 2^ADDR_W-1 to 0 with no flag. An immediate fetched across the wrap comes from address 0.
- Halt detection looks only at instruction words, never at immediate words. An immediate of 16'hFFFF is legal data.
- DIN is driven combinationally from state plus the instr/imm registers. Outside ISSUE/EXEC, DIN=0.

## Timing
- Memory read latency is exactly 1 cycle. mem_addr during cycle t yields mem_data sampled at the edge ending cycle t+1 (the LOAD/IMM_LOAD edge).
- Non-mvi instruction: Start sampled high in IDLE at edge 0 → Run=1 during cycle 3 (after FETCH and LOAD).
- mvi instruction: same timing plus 2 cycles (IMM_FETCH, IMM_LOAD).
- Immediate word appears on DIN exactly 1 cycle after Run rises.
- Back-to-back retirement: Done in EXEC → FETCH on the next cycle. Run falls for 2 cycles (non-mvi) between instructions.
- Run remains high continuously from ISSUE until the edge at which Done is sampled. There is no Run bubble within an instruction.
- Halted rises on the cycle after the LOAD edge.

## Structure
- Shared package `fetch_pkg`:
  - state enum: IDLE, FETCH, LOAD, IMM_FETCH, IMM_LOAD, ISSUE, EXEC, HALT.
  - opcode constants for mv, mvi, add, sub, and, slt, sll, srl (3'b000..3'b111).
  - HALT_MASK = 7'b1111111 for bits [15:9].
- One sub-module, `pc_counter`: ADDR_W-bit register with synchronous active-low clear and an increment enable, wrapping modulo 2^ADDR_W.
- FSM, instr/imm registers and DIN mux live in instr_fetch.

## Test plan
- mv program: mem[0]=16'h0001 (mv R0,R1), Start=1, Done pulsed 2 cycles after Run rises → DIN=16'h0001 with Run=1 from cycle 3. pc=1 after LOAD. Next FETCH issues mem_addr=1.
- mvi sequence: mem[0]=16'h0040 (mvi R0), mem[1]=16'h1234 → DIN=16'h0040 on the first Run cycle, then 16'h1234 until Done. pc=2. The next instruction is fetched from address 2.
- Halt: mem[2]=16'hFE00 after two instructions → Halted=1, Run=0, pc=3. Start toggling causes no further mem_addr change until Resetn=0.
- Wrap: ADDR_W=2, four non-mvi words with Done returned each time → pc sequence 1,2,3,0, and mem_addr=0 is re-fetched.
- Reset mid-EXEC: Resetn=0 for one edge while Run=1 → next cycle Run=0, DIN=0, pc=0, state IDLE. Restart fetches address 0.
- Done held high through ISSUE → ignored. Retirement occurs at the first EXEC edge. DIN is held stable for the full ISSUE cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/sequencing stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    IMM_FETCH,
    IMM_LOAD,
    ISSUE,
    EXEC,
    HALT
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  // Compared against word bits [15:9]
  localparam logic [6:0] HALT_MASK = 7'b1111111;

endpackage

// File: rtl/instr_fetch_pc_counter.sv
// Program counter: synchronous active-low clear, increment enable,
// wraps modulo 2^ADDR_W.
module pc_counter #(
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_clr_n,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_count
);

  logic [ADDR_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + ADDR_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Fetch/sequencing stage: walks pc through a 1-cycle-latency memory and
// presents each instruction (plus mvi immediate) to the core until Done.
//
// state     | meaning
// IDLE      | waiting for Start
// FETCH     | instruction address on mem_addr
// LOAD      | capture instruction, pc+1, decode halt/mvi
// IMM_FETCH | immediate address on mem_addr
// IMM_LOAD  | capture immediate, pc+1
// ISSUE     | Run=1, DIN=instr, Done ignored
// EXEC      | Run=1, DIN=imm (mvi) or instr, wait for Done
// HALT      | Halted=1, locked until reset
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int         ADDR_W = 5,
  parameter int         DATA_W = 16,
  parameter logic [2:0] MVI_OP = OP_MVI
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Done,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic              Halted,
  output logic [ADDR_W-1:0] pc
);

  state_t            r_state;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_imm;
  logic              r_run;
  logic              r_halted;
  logic              w_pc_inc;
  logic              w_instr_mvi;
  logic [ADDR_W-1:0] w_pc;

  assign w_pc_inc = (r_state == LOAD) || (r_state == IMM_LOAD);

  pc_counter #(.ADDR_W(ADDR_W)) u_pc (
    .i_clk   (Clock),
    .i_clr_n (Resetn),
    .i_inc   (w_pc_inc),
    .o_count (w_pc)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state  <= IDLE;
      r_instr  <= '0;
      r_imm    <= '0;
      r_run    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) r_state <= FETCH;
        end
        FETCH: r_state <= LOAD;
        LOAD: begin
          r_instr <= mem_data;
          if (mem_data[15:9] == HALT_MASK) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else if (mem_data[8:6] == MVI_OP) begin
            r_state <= IMM_FETCH;
          end else begin
            r_state <= ISSUE;
            r_run   <= 1'b1;
          end
        end
        IMM_FETCH: r_state <= IMM_LOAD;
        IMM_LOAD: begin
          r_imm   <= mem_data;
          r_state <= ISSUE;
          r_run   <= 1'b1;
        end
        ISSUE: r_state <= EXEC;
        EXEC: begin
          if (Done) begin
            r_run   <= 1'b0;
            r_state <= Start ? FETCH : IDLE;
          end
        end
        HALT: r_state <= HALT;
        default: begin
          r_state <= IDLE;
          r_run   <= 1'b0;
        end
      endcase
    end
  end

  assign w_instr_mvi = (r_instr[8:6] == MVI_OP);

  always_comb begin
    DIN = '0;
    case (r_state)
      ISSUE:   DIN = r_instr;
      EXEC:    DIN = w_instr_mvi ? r_imm : r_instr;
      default: DIN = '0;
    endcase
  end

  // pc is only ever advanced in LOAD/IMM_LOAD, so it is the fetch address
  // in every state that reads memory.
  assign mem_addr = w_pc;
  assign pc       = w_pc;
  assign Run      = r_run;
  assign Halted   = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-walking reference model
// queues expected issues; a negedge monitor pops and compares.
module tb_instr_fetch;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int DEPTH = 32;

  logic          Clock  = 1'b0;
  logic          Resetn = 1'b0;
  logic          Start  = 1'b0;
  logic          Done   = 1'b0;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] DIN;
  logic          Run;
  logic          Halted;
  logic [AW-1:0] pc;

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .MVI_OP(3'b001)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Start    (Start),
    .Done     (Done),
    .mem_data (mem_data),
    .mem_addr (mem_addr),
    .DIN      (DIN),
    .Run      (Run),
    .Halted   (Halted),
    .pc       (pc)
  );

  always #5 Clock = ~Clock;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge Clock) mem_data <= mem[mem_addr];

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    bit          mvi;
    int          pc_after;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int   len_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, req, req, $time);
  endtask

  // ---------------- monitor ----------------
  bit   run_prev = 0, halt_prev = 0, have_cur = 0, skip_len = 0;
  int   low_cnt = 0, run_cnt = 0, halted_gap = -1;
  exp_t cur;

  always @(negedge Clock) begin
    if (Run) begin
      if (!run_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_run", 1, 0);
          have_cur = 0;
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
          check("issue_din", DIN, cur.instr);
          check("issue_pc", pc, cur.pc_after);
          if (cur.gap >= 0) check("fetch_gap", low_cnt, cur.gap);
        end
        run_cnt = 1;
      end else begin
        if (have_cur) check("exec_din", DIN, cur.mvi ? cur.imm : cur.instr);
        run_cnt++;
      end
    end else begin
      if (run_prev) begin
        if (skip_len) skip_len = 0;
        else if (len_q.size() > 0) check("run_len", run_cnt, len_q.pop_front());
        else check("run_len_missing", 1, 0);
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
      check("idle_din", DIN, 0);
    end
    if (Halted && !halt_prev) halted_gap = low_cnt;
    run_prev  = Run;
    halt_prev = Halted;
  end

  // ---------------- reference model ----------------
  int m_pc   = 0;
  bit m_first = 1;

  function automatic bit model_step(output exp_t e);
    logic [15:0] w;
    w = mem[m_pc];
    m_pc = (m_pc + 1) % DEPTH;
    e.instr = w;
    e.imm = 16'h0;
    e.mvi = 0;
    e.pc_after = m_pc;
    e.gap = -1;
    if (w[15:9] == 7'h7F) return 1;
    e.mvi = (w[8:6] == 3'b001);
    if (e.mvi) begin
      e.imm = mem[m_pc];
      m_pc = (m_pc + 1) % DEPTH;
    end
    e.pc_after = m_pc;
    e.gap = m_first ? -1 : (e.mvi ? 4 : 2);
    m_first = 0;
    return 0;
  endfunction

  task automatic gen_prog(input bit with_halt);
    bit prev_mvi = 0;
    for (int i = 0; i < DEPTH; i++) begin
      int r;
      logic [6:0] hi;
      logic [2:0] op;
      logic [5:0] lo;
      r  = $urandom_range(0, 9);
      hi = 7'($urandom_range(0, 126));
      lo = 6'($urandom);
      op = (r < 3) ? 3'b001 : 3'($urandom_range(0, 7));
      if (r >= 3 && op == 3'b001) op = 3'b000;
      mem[i] = {hi, op, lo};
      if (with_halt && r == 9) mem[i] = {7'h7F, 9'($urandom)};
      if (with_halt && prev_mvi && $urandom_range(0, 2) == 0) mem[i] = 16'hFFFF;
      prev_mvi = (mem[i][8:6] == 3'b001) && (mem[i][15:9] != 7'h7F);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic do_reset();
    Resetn = 0; Done = 0; Start = 0;
    repeat (2) @(negedge Clock);
    check("rst_run", Run, 0);
    check("rst_din", DIN, 0);
    check("rst_halted", Halted, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_pc", pc, 0);
    Resetn = 1;
    m_pc = 0; m_first = 1; halted_gap = -1;
  endtask

  task automatic wait_run(output bit ok);
    int t = 0;
    ok = 1;
    do begin
      @(negedge Clock);
      t++;
    end while (!Run && t < 40);
    if (!Run) begin
      check("run_timeout", 0, 1);
      ok = 0;
    end
  endtask

  task automatic drive_instr(input bit drop_start);
    bit ok;
    int k;
    wait_run(ok);
    if (!ok) return;
    k = $urandom_range(0, 3);
    len_q.push_back(k == 0 ? 2 : k + 1);
    if (drop_start) Start = 0;
    if (k == 0) begin
      Done = 1;
      repeat (2) @(negedge Clock);
      Done = 0;
    end else begin
      repeat (k) @(negedge Clock);
      Done = 1;
      @(negedge Clock);
      Done = 0;
    end
  endtask

  task automatic run_program(input int max_n, input bit drop_last, output bit halted);
    exp_t e;
    halted = 0;
    for (int i = 0; i < max_n; i++) begin
      bit first_before;
      first_before = m_first;
      if (model_step(e)) begin
        int t = 0;
        halted = 1;
        while (!Halted && t < 20) begin
          @(negedge Clock);
          t++;
        end
        if (!Halted) check("halt_timeout", 0, 1);
        @(negedge Clock);
        check("halt_pc", pc, m_pc);
        check("halt_run", Run, 0);
        check("halt_din", DIN, 0);
        if (!first_before) check("halt_latency", halted_gap, 3);
        m_first = 1;
        return;
      end
      exp_q.push_back(e);
      drive_instr(drop_last && (i == max_n - 1));
    end
    if (drop_last) m_first = 1;
  endtask

  initial begin
    bit halted;
    logic [AW-1:0] addr_snap;
    exp_t e;
    bit ok;

    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0;
    do_reset();

    // directed: mv, mvi 1234, mvi with all-ones immediate, then halt
    gen_prog(0);
    mem[0] = 16'h0001; mem[1] = 16'h0040; mem[2] = 16'h1234;
    mem[3] = 16'h0040; mem[4] = 16'hFFFF; mem[5] = 16'hFE00;
    Start = 1;
    run_program(10, 0, halted);
    check("directed_halted", halted, 1);
    check("directed_halt_pc", pc, 6);
    addr_snap = mem_addr;
    for (int i = 0; i < 6; i++) begin
      Start = ~Start;
      @(negedge Clock);
    end
    check("halt_addr_frozen", mem_addr, addr_snap);
    check("halt_sticky", Halted, 1);
    do_reset();

    // random no-halt program, long enough to wrap pc; drop Start at the end
    gen_prog(0);
    Start = 1;
    run_program(45, 1, halted);
    repeat (4) @(negedge Clock);
    check("idle_run", Run, 0);
    check("idle_pc", pc, m_pc);
    check("idle_addr", mem_addr, m_pc);

    // resume from idle, then reset in the middle of an instruction
    Start = 1;
    run_program(5, 0, halted);
    mem[m_pc] = 16'h0001;
    void'(model_step(e));
    exp_q.push_back(e);
    wait_run(ok);
    @(negedge Clock);
    skip_len = 1;
    Resetn = 0;
    @(negedge Clock);
    check("midrst_run", Run, 0);
    check("midrst_din", DIN, 0);
    check("midrst_pc", pc, 0);
    check("midrst_addr", mem_addr, 0);
    Resetn = 1;
    m_pc = 0; m_first = 1;

    // random program with halts and all-ones immediates, restart from 0
    gen_prog(1);
    run_program(200, 0, halted);
    check("final_halted", Halted, halted);

    check("exp_q_drained", exp_q.size(), 0);
    check("len_q_drained", len_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
